// File: rtl/bram_wnd_sched.sv
// Frame scheduler for the grey-conversion window path: issues one AXI burst at a time,
// tracks window-BRAM fill from converter writes and consumer row releases.
module bram_wnd_sched #(
    parameter int unsigned ROW_PX       = 640,
    parameter int unsigned FRAME_ROWS   = 480,
    parameter int unsigned WND_ROWS     = 8,
    parameter int unsigned BURST_PX     = 128,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int unsigned BYTES_PER_PX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic [11:0] rd_len,
    input  logic        rd_ack,
    input  logic        rd_done,
    input  logic        px_wr,
    input  logic        row_release,
    output logic        wnd_ready,
    output logic [15:0] fill_lvl,
    output logic        busy,
    output logic        frame_done,
    output logic        err
);
    localparam int unsigned WND_PX       = WND_ROWS * ROW_PX;
    localparam int unsigned TOTAL_BURSTS = ROW_PX * FRAME_ROWS / BURST_PX;
    localparam int unsigned BW           = $clog2(TOTAL_BURSTS + 1);
    localparam int unsigned RW           = $clog2(FRAME_ROWS + 1);
    localparam logic [31:0] STRIDE       = 32'(BURST_PX * BYTES_PER_PX);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DRAIN} state_t;

    state_t        state;
    logic [BW-1:0] burst_idx;
    logic [RW-1:0] rows_released;
    // err stays clear after reset until the first start, so stray traffic is harmless
    logic          armed;

    logic        px_ok, px_bad, rel_ok, rel_bad;
    logic [15:0] fill_next;

    assign rd_len = 12'(BURST_PX);

    always_comb begin
        px_ok     = px_wr && (state != IDLE) && (fill_lvl != 16'(WND_PX));
        px_bad    = px_wr && ((state == IDLE) || (fill_lvl == 16'(WND_PX)));
        rel_ok    = row_release && (fill_lvl >= 16'(ROW_PX));
        rel_bad   = row_release && !rel_ok;
        fill_next = fill_lvl;
        if (px_ok)  fill_next = fill_next + 16'd1;
        if (rel_ok) fill_next = fill_next - 16'(ROW_PX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            burst_idx     <= '0;
            rows_released <= '0;
            armed         <= 1'b0;
            rd_req        <= 1'b0;
            rd_addr       <= BASE_ADDR;
            wnd_ready     <= 1'b0;
            fill_lvl      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            err           <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            fill_lvl   <= fill_next;
            if (rel_ok) rows_released <= rows_released + RW'(1);
            if (armed && (px_bad || rel_bad)) err <= 1'b1;
            wnd_ready <= (fill_lvl >= 16'(WND_PX)) ||
                         ((state == DRAIN) && (fill_lvl >= 16'(ROW_PX)));
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= ISSUE;
                        busy          <= 1'b1;
                        armed         <= 1'b1;
                        err           <= 1'b0;
                        burst_idx     <= '0;
                        rows_released <= '0;
                        fill_lvl      <= '0;
                        rd_addr       <= BASE_ADDR;
                    end
                end
                ISSUE: begin
                    if (burst_idx == BW'(TOTAL_BURSTS)) begin
                        state <= DRAIN;
                    end else if (32'(fill_lvl) + BURST_PX <= WND_PX) begin
                        rd_req <= 1'b1;
                        state  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // address advances on acceptance so it is already correct at the next issue
                    if (rd_ack) begin
                        rd_req    <= 1'b0;
                        burst_idx <= burst_idx + BW'(1);
                        rd_addr   <= rd_addr + STRIDE;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (rd_done) state <= ISSUE;
                end
                DRAIN: begin
                    if (rows_released == RW'(FRAME_ROWS)) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_wnd_sched.sv
// Randomized bench for bram_wnd_sched: default-size instance for priming/throttle/error cases,
// small instance (wrapping base address) for a complete frame.
module tb_bram_wnd_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_d = 1'b0, start_s = 1'b0;
    logic rd_ack = 1'b0, rd_done = 1'b0, px_wr = 1'b0, row_release = 1'b0;

    logic        d_rd_req, s_rd_req, d_wnd_ready, s_wnd_ready, d_busy, s_busy;
    logic        d_frame_done, s_frame_done, d_err, s_err;
    logic [31:0] d_rd_addr, s_rd_addr;
    logic [11:0] d_rd_len, s_rd_len;
    logic [15:0] d_fill, s_fill;

    logic        sel = 1'b0;
    logic        o_rd_req, o_wnd_ready, o_busy, o_frame_done, o_err;
    logic [31:0] o_rd_addr;
    logic [11:0] o_rd_len;
    logic [15:0] o_fill;

    int unsigned n_checks = 0, n_errors = 0;
    int          m_fill, m_rows, m_row, m_wnd, m_burst;
    bit          m_err, m_armed, m_active, auto_rel, fd_busy;
    logic [31:0] m_base, m_stride;
    int unsigned bursts, fd_cnt;

    always #5 clk = ~clk;

    bram_wnd_sched dut_d (
        .clk(clk), .rst(rst), .start(start_d), .rd_req(d_rd_req), .rd_addr(d_rd_addr),
        .rd_len(d_rd_len), .rd_ack(rd_ack), .rd_done(rd_done), .px_wr(px_wr),
        .row_release(row_release), .wnd_ready(d_wnd_ready), .fill_lvl(d_fill),
        .busy(d_busy), .frame_done(d_frame_done), .err(d_err)
    );

    bram_wnd_sched #(
        .ROW_PX(64), .FRAME_ROWS(24), .WND_ROWS(4), .BURST_PX(16),
        .BASE_ADDR(32'hFFFF_FF00), .BYTES_PER_PX(2)
    ) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .rd_req(s_rd_req), .rd_addr(s_rd_addr),
        .rd_len(s_rd_len), .rd_ack(rd_ack), .rd_done(rd_done), .px_wr(px_wr),
        .row_release(row_release), .wnd_ready(s_wnd_ready), .fill_lvl(s_fill),
        .busy(s_busy), .frame_done(s_frame_done), .err(s_err)
    );

    assign o_rd_req     = sel ? s_rd_req     : d_rd_req;
    assign o_rd_addr    = sel ? s_rd_addr    : d_rd_addr;
    assign o_rd_len     = sel ? s_rd_len     : d_rd_len;
    assign o_wnd_ready  = sel ? s_wnd_ready  : d_wnd_ready;
    assign o_fill       = sel ? s_fill       : d_fill;
    assign o_busy       = sel ? s_busy       : d_busy;
    assign o_frame_done = sel ? s_frame_done : d_frame_done;
    assign o_err        = sel ? s_err        : d_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill = 0; m_rows = 0; m_err = 0; m_armed = 0; m_active = 0;
        bursts = 0; fd_cnt = 0;
    endtask

    // Frame-level view of the window: pixel and row counts per the fill rules.
    task automatic model_step();
        bit px_ok, px_bad, rel_ok;
        px_ok  = m_active && px_wr && (m_fill != m_wnd);
        px_bad = px_wr && (!m_active || (m_fill == m_wnd));
        rel_ok = row_release && (m_fill >= m_row);
        if (m_armed && (px_bad || (row_release && !rel_ok))) m_err = 1;
        m_fill = m_fill + (px_ok ? 1 : 0) - (rel_ok ? m_row : 0);
        if (rel_ok) m_rows++;
        if ((sel ? start_s : start_d) && !m_active) begin
            m_active = 1; m_armed = 1; m_err = 0; m_fill = 0; m_rows = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_step();
        #1;
        start_d = 0; start_s = 0; rd_ack = 0; rd_done = 0; px_wr = 0; row_release = 0;
        if (o_frame_done) begin
            fd_cnt++;
            fd_busy  = o_busy;
            m_active = 0;
        end
        if (auto_rel && o_wnd_ready && m_fill >= m_row) row_release = 1;
    endtask

    task automatic wait_req(input int unsigned budget);
        int unsigned i = 0;
        while (!o_rd_req && i < budget) begin
            cycle();
            i++;
        end
        check("req_seen", o_rd_req, 1);
    endtask

    task automatic write_px(input int unsigned k);
        int unsigned w = 0;
        while (w < k) begin
            px_wr = ($urandom_range(0, 3) != 0);
            if (px_wr) w++;
            cycle();
        end
    endtask

    task automatic serve(input int unsigned npx, input int unsigned ack_dly);
        logic [31:0] ea;
        wait_req(400);
        ea = m_base + 32'(bursts) * m_stride;
        check("rd_addr", o_rd_addr, ea);
        check("rd_len", 32'(o_rd_len), 32'(m_burst));
        repeat (ack_dly) cycle();
        rd_ack = 1;
        cycle();
        check("req_drop", o_rd_req, 0);
        bursts++;
        write_px(npx);
    endtask

    task automatic burst_done();
        rd_done = 1;
        cycle();
    endtask

    task automatic do_reset();
        rst = 0;
        model_reset();
        repeat (3) cycle();
        rst = 1;
        cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw;
        m_row = 640; m_wnd = 5120; m_burst = 128; m_base = 32'h0; m_stride = 32'd256;
        auto_rel = 0; fd_busy = 1;
        do_reset();

        check("rst_rd_req", o_rd_req, 0);
        check("rst_rd_addr", o_rd_addr, 32'h0);
        check("rst_rd_len", 32'(o_rd_len), 32'd128);
        check("rst_wnd_ready", o_wnd_ready, 0);
        check("rst_fill", 32'(o_fill), 0);
        check("rst_busy", o_busy, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_err", o_err, 0);
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) begin px_wr = 1; row_release = 1; end
            cycle();
            saw |= o_rd_req;
        end
        check("idle_no_req", saw, 0);
        check("idle_err_held_clear", o_err, 0);

        // Prime the window: 40 bursts fill it exactly.
        start_d = 1;
        cycle();
        check("start_busy", o_busy, 1);
        cycle();
        check("first_req_latency", o_rd_req, 1);
        for (int i = 0; i < 40; i++) begin
            serve(128, 2);
            burst_done();
        end
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 3) rd_ack = 1;
            cycle();
            saw |= o_rd_req;
        end
        check("stall_41st", saw, 0);
        check("full_fill", 32'(o_fill), 32'd5120);
        check("full_fill_model", 32'(o_fill), 32'(m_fill));
        check("full_wnd_ready", o_wnd_ready, 1);

        // Throttle release and resume.
        row_release = 1;
        cycle();
        check("release_fill", 32'(o_fill), 32'd4480);
        check("release_ready_lag", o_wnd_ready, 1);
        check("release_no_req_yet", o_rd_req, 0);
        cycle();
        check("resume_req", o_rd_req, 1);
        check("resume_addr", o_rd_addr, 32'h2800);
        check("release_ready_drop", o_wnd_ready, 0);
        for (int i = 0; i < 4; i++) begin
            serve(128, $urandom_range(0, 2));
            burst_done();
        end
        serve(8, 0);
        check("fill_5000", 32'(o_fill), 32'd5000);
        px_wr = 1;
        row_release = 1;
        cycle();
        check("simul_fill", 32'(o_fill), 32'd4361);
        check("simul_err", o_err, 0);
        write_px(119);
        burst_done();
        check("after_simul_fill", 32'(o_fill), 32'd4480);
        check("after_simul_model", 32'(o_fill), 32'(m_fill));

        // Underflowing release, then reset while a request is pending.
        do_reset();
        start_d = 1;
        cycle();
        serve(100, 0);
        check("fill_100", 32'(o_fill), 32'd100);
        row_release = 1;
        cycle();
        check("underflow_fill", 32'(o_fill), 32'd100);
        check("underflow_err", o_err, 1);
        check("underflow_err_model", o_err, m_err);
        write_px(28);
        burst_done();
        wait_req(20);
        cycle();
        rst = 0;
        #2;
        check("async_rst_req", o_rd_req, 0);
        check("async_rst_busy", o_busy, 0);
        model_reset();
        cycle();
        rst = 1;
        rd_done = 1;
        cycle();
        px_wr = 1;
        row_release = 1;
        cycle();
        cycle();
        check("post_rst_busy", o_busy, 0);
        check("post_rst_err", o_err, 0);
        check("post_rst_fill", 32'(o_fill), 0);
        check("post_rst_req", o_rd_req, 0);

        // Full frame on the small instance with a release-on-ready consumer.
        sel = 1;
        m_row = 64; m_wnd = 256; m_burst = 16; m_base = 32'hFFFF_FF00; m_stride = 32'd32;
        model_reset();
        auto_rel = 1;
        start_s = 1;
        cycle();
        for (int i = 0; i < 96; i++) begin
            serve(16, $urandom_range(0, 2));
            burst_done();
        end
        for (int i = 0; i < 3000 && fd_cnt == 0; i++) cycle();
        check("frame_done_seen", fd_cnt, 1);
        check("frame_done_busy", fd_busy, 0);
        check("frame_rows", 32'(m_rows), 32'd24);
        check("frame_err", o_err, 0);
        check("frame_fill", 32'(o_fill), 0);
        repeat (5) cycle();
        check("frame_done_once", fd_cnt, 1);
        check("frame_idle_busy", o_busy, 0);
        auto_rel = 0;
        px_wr = 1;
        cycle();
        check("idle_px_err", o_err, 1);
        check("idle_px_err_model", o_err, m_err);
        check("idle_px_fill", 32'(o_fill), 0);
        start_s = 1;
        cycle();
        check("start_clears_err", o_err, 0);
        check("restart_busy", o_busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_wnd_sched.md
# bram_wnd_sched

Frame-level scheduler for the grey-conversion window path. It issues AXI burst-read requests for one frame and counts pixels as the converter writes them into the window BRAM. It tracks how many rows the downstream window consumer still holds, and throttles bursts so the ring-buffer BRAM never overruns. It sits between the AXI read master, the pixel converter's BRAM write strobe and the window-processing consumer.

## Interface
Parameters:
- ROW_PX, 640, pixels per image row
- FRAME_ROWS, 480, rows per frame
- WND_ROWS, 8, rows held in window BRAM; WND_PX = WND_ROWS*ROW_PX (5120 = 0x1400)
- BURST_PX, 128, pixels per AXI burst; ROW_PX*FRAME_ROWS must be a multiple of it
- BASE_ADDR, 32'h0, frame base byte address
- BYTES_PER_PX, 2, source bytes per pixel (RGB565)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a frame; ignored while busy
- rd_req  out  1  burst request to AXI master
- rd_addr  out  32  burst byte address, valid while rd_req
- rd_len  out  12  burst length in pixels (= BURST_PX), valid while rd_req
- rd_ack  in  1  master accepted the current request
- rd_done  in  1  pulse; last beat of accepted burst delivered
- px_wr  in  1  one pixel written to window BRAM this cycle
- row_release  in  1  pulse; consumer frees ROW_PX pixels
- wnd_ready  out  1  window BRAM holds a processable window
- fill_lvl  out  16  pixels currently resident in BRAM
- busy  out  1  frame in progress
- frame_done  out  1  single-cycle pulse at frame completion
- err  out  1  sticky protocol error; cleared by reset or start

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DRAIN.
- IDLE: on start, clear burst_idx, fill, inflight and rows_released; clear err; go to ISSUE.
- ISSUE: if burst_idx == TOTAL_BURSTS (ROW_PX*FRAME_ROWS/BURST_PX = 2400), go to DRAIN.
- ISSUE: else if fill + BURST_PX <= WND_PX, assert rd_req, set inflight = BURST_PX and go to WAIT_ACK.
- ISSUE: else stall in ISSUE.
- WAIT_ACK: hold rd_req, rd_addr and rd_len stable. On rd_ack, drop rd_req next cycle, increment burst_idx and go to WAIT_DONE.
- WAIT_DONE: on rd_done, clear inflight and go to ISSUE.
- At most one burst is outstanding.
- rd_addr = BASE_ADDR + burst_idx*BURST_PX*BYTES_PER_PX, wrapping at 32 bits.
- fill accounting, every cycle: fill_next = fill + px_wr − (row_release ? ROW_PX : 0). Simultaneous px_wr and row_release apply both.
- row_release with fill < ROW_PX: the release is ignored, err is set, and fill is unchanged except for px_wr.
- px_wr with fill == WND_PX: err is set and fill saturates at WND_PX.
- px_wr in IDLE: ignored, err is set.
- The issue check uses fill only. Pixels in flight are excluded because only one burst is outstanding and the check precedes request.
- rows_released increments on each accepted row_release.
- wnd_ready = (fill >= WND_PX) OR (state == DRAIN AND fill >= ROW_PX). Registered.
- DRAIN: when rows_released == FRAME_ROWS, pulse frame_done for one cycle and go to IDLE.
- busy = (state != IDLE).
- Reset mid-frame: all state is abandoned immediately. rd_req drops asynchronously. Late rd_done, px_wr or row_release after reset are ignored and do not set err, because err is held clear until start.

## Timing
- Reset values: rd_req 0, rd_addr BASE_ADDR, rd_len BURST_PX, wnd_ready 0, fill_lvl 0, busy 0, frame_done 0, err 0, state IDLE.
- All outputs are registered.
- start sampled at edge N gives busy=1 and state ISSUE at N+1, and rd_req=1 at N+2 when space exists.
- rd_ack sampled at edge M gives rd_req=0 and burst_idx+1 at M+1. rd_ack is ignored when rd_req=0.
- rd_done sampled at edge K gives ISSUE at K+1 and the next rd_req at K+2 at the earliest.
- fill_lvl reflects px_wr and row_release one cycle after the sampling edge. wnd_ready follows fill_lvl with one further cycle.
- frame_done is high for exactly one cycle; busy falls on that same cycle.

## Test plan
- Reset then idle: rst low for 3 cycles, then high -> all outputs at reset values; rd_req stays 0 with no start.
- Prime: start, ack each burst after 2 cycles, 128 px_wr per burst, no releases -> exactly 40 bursts at addresses 0x0, 0x100 … 0x2700. The 41st request stalls. wnd_ready=1 once fill_lvl=5120.
- Throttle/resume: from full window, pulse row_release -> fill_lvl 4480 next cycle, and rd_req reasserts with rd_addr 0x2800 two cycles later.
- Simultaneous events: px_wr and row_release on the same cycle at fill 5000 -> fill_lvl 4361, err 0.
- Full frame: stream all 2400 bursts with consumer releasing rows as wnd_ready -> after 480th release, frame_done pulses once, busy 0, err 0.
- Errors and reset: row_release at fill 100 -> err=1, fill 100. Then assert rst mid-WAIT_ACK -> rd_req 0 immediately; a later rd_done leaves state IDLE and err 0.
